// File: rtl/mem_stage_vls_pkg.sv
// Shared types and constants for the vector load/store MEM stage.
package vmem_pkg;

  localparam int VMEM_N           = 32;
  localparam int VMEM_V           = 20;
  localparam int VMEM_CW          = $clog2(VMEM_V + 1);
  localparam int VMEM_WORD_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } vmem_state_t;

  typedef struct packed {
    logic               we;
    logic               vec;
    logic [VMEM_N-1:0]  base;
    logic [VMEM_CW-1:0] len;
  } vmem_req_t;

  // Number of word accesses an op expands into.
  function automatic logic [VMEM_CW-1:0] vmem_len(input logic vec);
    return vec ? VMEM_CW'(VMEM_V) : VMEM_CW'(1);
  endfunction

endpackage

// File: rtl/mem_stage_vls_if.sv
// Data-memory bus between the MEM stage (master) and a single-port, 1-cycle-read memory (slave).
interface mem_stage_vls_if #(
  parameter int N = 32
);
  logic [N-1:0] mem_addr_o;
  logic [N-1:0] mem_wdata_o;
  logic         mem_we_o;
  logic [N-1:0] mem_rdata_i;

  modport master (
    output mem_addr_o,
    output mem_wdata_o,
    output mem_we_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_we_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_vls_addr_gen.sv
// Element counter and strided address generator for serialised vector accesses.
module vmem_addr_gen #(
  parameter int N  = 32,
  parameter int V  = 20,
  parameter int CW = $clog2(V + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_i,
  input  logic          advance_i,
  input  logic [CW-1:0] len_i,
  input  logic [N-1:0]  base_i,
  input  logic [N-1:0]  stride_i,
  output logic [CW-1:0] idx_o,
  output logic [N-1:0]  addr_o,
  output logic          last_o
);

  logic [CW-1:0] idx_q;
  logic [CW-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (start_i) begin
      idx_d = '0;
    end else if (advance_i) begin
      idx_d = idx_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  // addr_o is the address of element idx+1: the top registers it as the next bus address.
  assign addr_o = base_i + N'(idx_q + CW'(1)) * stride_i;
  assign last_o = (idx_q == len_i - CW'(1));

endmodule

// File: rtl/mem_stage_vls.sv
// MEM stage: scalar/vector loads and stores serialised onto a word-wide synchronous memory.
// Optional VMEM_STRIDE_EN adds a per-op byte stride input; otherwise the stride is one word.
module mem_stage_vls
  import vmem_pkg::*;
#(
  parameter int N = VMEM_N,
  parameter int V = VMEM_V
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                MemWE_i,
  input  logic                WBSelect_i,
  input  logic                OpSource_i,
  input  logic [N-1:0]        AluResult_S_i,
  input  logic [N-1:0]        RD2_S_i,
  input  logic [V*N-1:0]      RD2_V_i,
`ifdef VMEM_STRIDE_EN
  input  logic [N-1:0]        stride_i,
`endif
  mem_stage_vls_if.master     mem,
  output logic                stall_o,
  output logic                done_o,
  output logic [N-1:0]        ReadData_S_o,
  output logic [V*N-1:0]      ReadData_V_o
);

  localparam int CW = $clog2(V + 1);

  vmem_state_t   state_q;
  vmem_req_t     req_q;
  logic [N-1:0]  stride_q;
  logic [N-1:0]  sdata_q [V];
  logic [N-1:0]  mem_addr_q;
  logic [N-1:0]  mem_wdata_q;
  logic          mem_we_q;
  logic          done_q;
  logic [N-1:0]  rdata_s_q;

  logic          req;
  logic          accept;
  logic [N-1:0]  stride_in;
  logic [CW-1:0] idx;
  logic [N-1:0]  next_addr;
  logic          last;
  logic          advance;
  logic [N-1:0]  wdata_next;
  logic [CW-1:0] cap_idx;
  logic          capture_en;

  assign req    = MemWE_i | WBSelect_i;
  assign accept = RST && (state_q == IDLE) && req;

`ifdef VMEM_STRIDE_EN
  assign stride_in = stride_i;
`else
  assign stride_in = N'(VMEM_WORD_STRIDE);
`endif

  assign advance = (state_q == ACCESS) && !last;

  vmem_addr_gen #(
    .N  (N),
    .V  (V),
    .CW (CW)
  ) u_addr_gen (
    .CLK       (CLK),
    .RST       (RST),
    .start_i   (accept),
    .advance_i (advance),
    .len_i     (req_q.len),
    .base_i    (req_q.base),
    .stride_i  (stride_q),
    .idx_o     (idx),
    .addr_o    (next_addr),
    .last_o    (last)
  );

  // Store data for the element issued at the next edge (idx+1).
  always_comb begin
    wdata_next = '0;
    for (int k = 0; k < V; k++) begin
      if (idx + CW'(1) == CW'(k)) begin
        wdata_next = sdata_q[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int k = 0; k < V; k++) begin
        sdata_q[k] <= RD2_V_i[k*N +: N];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      req_q       <= '0;
      stride_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            req_q.we   <= MemWE_i;
            req_q.vec  <= OpSource_i;
            req_q.base <= AluResult_S_i;
            req_q.len  <= vmem_len(OpSource_i);
            stride_q   <= stride_in;
            mem_addr_q <= AluResult_S_i;
            mem_we_q   <= MemWE_i;
            if (MemWE_i) begin
              mem_wdata_q <= OpSource_i ? RD2_V_i[N-1:0] : RD2_S_i;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (last) begin
            mem_we_q <= 1'b0;
            done_q   <= req_q.we;
            state_q  <= req_q.we ? DONE : DRAIN;
          end else begin
            mem_addr_q <= next_addr;
            if (req_q.we) begin
              mem_wdata_q <= wdata_next;
            end
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read data lags the address by one cycle, so ACCESS captures element idx-1 and DRAIN the last one.
  assign cap_idx    = (state_q == DRAIN) ? idx : idx - CW'(1);
  assign capture_en = !req_q.we &&
                      (((state_q == ACCESS) && (idx != '0)) || (state_q == DRAIN));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rdata_s_q <= '0;
    end else if (capture_en && !req_q.vec) begin
      rdata_s_q <= mem.mem_rdata_i;
    end
  end

  generate
    for (genvar gi = 0; gi < V; gi++) begin : g_velem
      logic [N-1:0] elem_q;
      always_ff @(posedge CLK) begin
        if (!RST) begin
          elem_q <= '0;
        end else if (capture_en && req_q.vec && (cap_idx == CW'(gi))) begin
          elem_q <= mem.mem_rdata_i;
        end
      end
      assign ReadData_V_o[gi*N +: N] = elem_q;
    end
  endgenerate

  assign stall_o         = accept || (state_q == ACCESS) || (state_q == DRAIN);
  assign done_o          = done_q;
  assign ReadData_S_o    = rdata_s_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;
  assign mem.mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_mem_stage_vls.sv
// Scoreboard bench for mem_stage_vls: random and directed ops against a word-addressed memory model.
`timescale 1ns/1ps
module tb_mem_stage_vls;

  localparam int N = 32;
  localparam int V = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           we_in, wb_in, vec_in;
  logic [N-1:0]   base_in, sd_in;
  logic [V*N-1:0] vd_in;
`ifdef VMEM_STRIDE_EN
  logic [N-1:0]   stride_in;
`endif
  logic           stall, done;
  logic [N-1:0]   rs;
  logic [V*N-1:0] rv;

  mem_stage_vls_if #(.N(N)) mif ();

  mem_stage_vls #(.N(N), .V(V)) dut (
    .CLK           (clk),
    .RST           (rst),
    .MemWE_i       (we_in),
    .WBSelect_i    (wb_in),
    .OpSource_i    (vec_in),
    .AluResult_S_i (base_in),
    .RD2_S_i       (sd_in),
    .RD2_V_i       (vd_in),
`ifdef VMEM_STRIDE_EN
    .stride_i      (stride_in),
`endif
    .mem           (mif),
    .stall_o       (stall),
    .done_o        (done),
    .ReadData_S_o  (rs),
    .ReadData_V_o  (rv)
  );

  // 16 KB word memory with 1-cycle synchronous read; unwritten words hold an address-derived pattern.
  logic [N-1:0] tb_mem [4096];
  logic         mem_init_done = 1'b0;

  function automatic logic [N-1:0] pat(input int i);
    return 32'hC0DE_0000 | N'(i);
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (mif.mem_we_o) begin
      tb_mem[mif.mem_addr_o[13:2]] <= mif.mem_wdata_o;
    end
    mif.mem_rdata_i <= tb_mem[mif.mem_addr_o[13:2]];
  end

  typedef struct packed {
    logic [7:0]     stall;
    logic [N-1:0]   rs;
    logic [V*N-1:0] rv;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] d;
  } wr_t;

  exp_t exp_q [$];
  wr_t  wr_q  [$];

  logic [N-1:0]   ref_mem [4096];
  logic [N-1:0]   model_rs;
  logic [V*N-1:0] model_rv;
  logic [N-1:0]   cur_stride;

  int checks = 0;
  int errors = 0;
  int ops_done = 0;

  task automatic check(input string nm, input logic [V*N-1:0] act, input logic [V*N-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
    end
  endtask

  // Monitor: pops expected writes on each write strobe and expected results on each done pulse.
  initial begin : monitor
    int   stall_cnt;
    exp_t e;
    wr_t  w;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0;
      end else begin
        if (mif.mem_we_o) begin
          if (wr_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            w = wr_q.pop_front();
            check("wr_addr", mif.mem_addr_o, w.a);
            check("wr_data", mif.mem_wdata_o, w.d);
          end
        end
        if (stall) stall_cnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("stall_cycles", stall_cnt, e.stall);
            check("ReadData_S", rs, e.rs);
            check("ReadData_V", rv, e.rv);
            ops_done++;
            $display("op %0d done: stall=%0d rs=%0h", ops_done, stall_cnt, rs);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Reference model: expand the op into its element addresses and update/read the model memory.
  task automatic do_op(input logic st, input logic vec, input logic both,
                       input logic [N-1:0] base, input logic [N-1:0] sd,
                       input logic [V*N-1:0] vd);
    int           len;
    logic [N-1:0] addr, d;
    exp_t         e;
    bit           seen;
    len = vec ? V : 1;
    for (int k = 0; k < len; k++) begin
      addr = base + N'(k) * cur_stride;
      if (st) begin
        d = vec ? vd[k*N +: N] : sd;
        ref_mem[addr[13:2]] = d;
        wr_q.push_back('{a: addr, d: d});
      end else begin
        d = ref_mem[addr[13:2]];
        if (vec) model_rv[k*N +: N] = d;
        else     model_rs = d;
      end
    end
    e.stall = st ? 8'(len + 1) : 8'(len + 2);
    e.rs    = model_rs;
    e.rv    = model_rv;
    exp_q.push_back(e);

    @(posedge clk); #1;
    we_in   = st;
    wb_in   = !st || both;
    vec_in  = vec;
    base_in = base;
    sd_in   = sd;
    vd_in   = vd;
`ifdef VMEM_STRIDE_EN
    stride_in = cur_stride;
`endif
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check("op_timeout", 0, 1);
    @(posedge clk); #1;
    we_in = 1'b0;
    wb_in = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_we"}, mif.mem_we_o, 0);
    check({tag, "_addr"}, mif.mem_addr_o, 0);
    check({tag, "_wdata"}, mif.mem_wdata_o, 0);
    check({tag, "_rs"}, rs, 0);
    check({tag, "_rv"}, rv, 0);
  endtask

  initial begin : stim
    logic [V*N-1:0] vd;
    we_in = 0; wb_in = 0; vec_in = 0; base_in = '0; sd_in = '0; vd_in = '0;
`ifdef VMEM_STRIDE_EN
    stride_in = '0;
`endif
    cur_stride = N'(vmem_pkg::VMEM_WORD_STRIDE);
    model_rs = '0;
    model_rv = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_zero_outputs("reset");

    // Scalar store of 0xDEAD at 0x40, then scalar load of it.
    do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'hDEAD, '0);
    do_op(1'b0, 1'b0, 1'b0, 32'h40, '0, '0);

    // Vector store of 1..V at 0x100, then vector load back.
    for (int k = 0; k < V; k++) vd[k*N +: N] = N'(k + 1);
    do_op(1'b1, 1'b1, 1'b0, 32'h100, '0, vd);
    do_op(1'b0, 1'b1, 1'b0, 32'h100, '0, '0);

    // Store and load both requested: store wins, scalar result untouched.
    do_op(1'b1, 1'b0, 1'b1, 32'h8, 32'h7, '0);

    // Reset in the middle of a vector load, at element 5.
    @(posedge clk); #1;
    we_in = 1'b0; wb_in = 1'b1; vec_in = 1'b1; base_in = 32'h200;
    repeat (6) @(posedge clk);
    #1;
    rst   = 1'b0;
    wb_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_rs = '0;
    model_rv = '0;
    check_zero_outputs("midop_reset");
    do_op(1'b0, 1'b1, 1'b0, 32'h100, '0, '0);

`ifdef VMEM_STRIDE_EN
    cur_stride = 32'd8;
    do_op(1'b0, 1'b1, 1'b0, 32'h200, '0, '0);
    cur_stride = 32'd0;
    do_op(1'b0, 1'b1, 1'b0, 32'h200, '0, '0);
    for (int k = 0; k < V; k++) vd[k*N +: N] = $urandom;
    do_op(1'b1, 1'b1, 1'b0, 32'h300, '0, vd);
    do_op(1'b0, 1'b0, 1'b0, 32'h300, '0, '0);
`endif

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < V; k++) vd[k*N +: N] = $urandom;
`ifdef VMEM_STRIDE_EN
      cur_stride = N'(4 * $urandom_range(0, 3));
`endif
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            N'({$urandom_range(0, 4095), 2'b00}), N'($urandom), vd);
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_writes", wr_q.size(), 0);
    check("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
